etc_lane_ctrl: RTL and testbench

Parametrised next-generation non-stop ETC lane controller. It supports N sequential vehicle sensors, averaged speed measurement through a sequential divider, overspeed flagging, segment timeout fault and a timed barrier hold. It sits between the lane sensor/E-pass reader front end and the lane reporting logic, and replaces the fixed three-sensor controller in `top`.

---
 rtl/etc_pkg.sv | 33 +++
 rtl/etc_seq_div.sv | 70 +++++++
 rtl/etc_lane_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_etc_lane_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/etc_pkg.sv
// Shared types and constants for the ETC lane controller.
// Speed numerator and divider width are derived from the lane geometry.
package etc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRANSIT,
    DIVIDE,
    DECIDE,
    HOLD
  } etc_state_e;

  localparam logic [1:0] EPASS_NONE  = 2'b00;
  localparam logic [1:0] EPASS_VALID = 2'b10;

  // cm * (ms per s): dividing by elapsed ms yields cm/s
  function automatic longint unsigned div_num(
    input int gap_cm,
    input int n_sens
  );
    return 64'(gap_cm) * 64'(n_sens - 1) * 64'd1000;
  endfunction

  function automatic int div_width(input longint unsigned num);
    int w;
    w = 0;
    for (int i = 0; i < 64; i++) begin
      if (num[i]) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/etc_seq_div.sv
// Restoring divider, one quotient bit per cycle.
// The first step is folded into the start cycle so ready lands N cycles later.
module etc_seq_div #(
  parameter int N = 20,
  parameter int D = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [D-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic         ready,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);

  logic [D-1:0]  rem_q, rem_in, rem_nx;
  logic [N-1:0]  quo_q, quo_in, quo_nx;
  logic [D-1:0]  dvs_q, dvs_in;
  logic [CW-1:0] cnt_q;
  logic          busy_q, ready_q;
  logic [D:0]    rem_sh;
  logic          ge;

  always_comb begin
    rem_in = busy_q ? rem_q : '0;
    quo_in = busy_q ? quo_q : dividend;
    dvs_in = busy_q ? dvs_q : divisor;
    rem_sh = {rem_in, quo_in[N-1]};
    ge     = rem_sh >= {1'b0, dvs_in};
    rem_nx = ge ? D'(rem_sh - {1'b0, dvs_in})
                : rem_sh[D-1:0];
    quo_nx = {quo_in[N-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (busy_q) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      end else if (start) begin
        rem_q  <= rem_nx;
        quo_q  <= quo_nx;
        dvs_q  <= divisor;
        cnt_q  <= CW'(N - 1);
        busy_q <= 1'b1;
      end
    end
  end

  assign quotient = quo_q;
  assign ready    = ready_q;
  assign busy     = busy_q;

endmodule

// File: rtl/etc_lane_ctrl.sv
// Non-stop ETC lane controller: N-sensor transit timing, averaged
// speed via sequential divide, overspeed, segment timeout, barrier hold.
module etc_lane_ctrl
  import etc_pkg::*;
#(
  parameter int NUM_SENSORS = 3,
  parameter int WIDTH_TIK   = 16,
  parameter int TIK_PER_MS  = 50000,
  parameter int WIDTH_MS    = 9,
  parameter int WIDTH_SPEED = 14,
  parameter int GAP_CM      = 500,
  parameter int SPEED_LIMIT = 3333,
  parameter int HOLD_MS     = 300
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SENSORS-1:0] sensor,
  input  logic [1:0]             valid_Epass,
  input  logic                   enable,
  output logic [WIDTH_SPEED-1:0] speed,
  output logic                   speed_valid,
  output logic                   done,
  output logic                   barrier,
  output logic                   overspeed,
  output logic                   fault
);

  localparam longint unsigned NUM = div_num(GAP_CM, NUM_SENSORS);
  localparam int DIV_W = div_width(NUM);
  localparam int TW    = WIDTH_MS + $clog2(NUM_SENSORS);
  localparam int SW    = $clog2(NUM_SENSORS);
  localparam int HW    = $clog2(HOLD_MS + 1);

  localparam logic [DIV_W-1:0]     DIVIDEND  = DIV_W'(NUM);
  localparam logic [WIDTH_TIK-1:0] TIK_LAST  = WIDTH_TIK'(TIK_PER_MS - 1);
  localparam logic [WIDTH_MS-1:0]  MS_MAX    = '1;
  localparam logic [SW-1:0]        SEG_LAST  = SW'(NUM_SENSORS - 1);
  localparam logic [HW-1:0]        HOLD_LAST = HW'(HOLD_MS - 1);
  localparam logic [31:0]          LIMIT     = 32'(SPEED_LIMIT);
  localparam longint unsigned      SPD_MAX   = (64'd1 << WIDTH_SPEED) - 1;

  logic [NUM_SENSORS-1:0] sync1_q, sync2_q, prev_q, rise;

  etc_state_e             state_q, state_d;
  logic [WIDTH_TIK-1:0]   tik_q, tik_d, tik_nx;
  logic [WIDTH_MS-1:0]    seg_ms_q, seg_ms_d;
  logic [TW-1:0]          total_q, total_d;
  logic [SW-1:0]          seg_q, seg_d;
  logic [1:0]             epass_q, epass_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [WIDTH_SPEED-1:0] speed_q, speed_d, spd_sat;
  logic                   over_q, over_d;
  logic                   fault_q, fault_d;
  logic                   barrier_q, barrier_d;
  logic                   sv_q, sv_d;
  logic                   done_q, done_d;
  logic                   ms_tick;

  logic [DIV_W-1:0] div_quo;
  logic             div_ready, div_busy, div_start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sensor;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

  assign div_start = (state_q == DIVIDE) && !div_busy && !div_ready;

  etc_seq_div #(
    .N (DIV_W),
    .D (TW)
  ) u_div (
    .clk      (clk),
    .rst_n    (reset_n),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  (total_q),
    .quotient (div_quo),
    .ready    (div_ready),
    .busy     (div_busy)
  );

  assign ms_tick = (tik_q == TIK_LAST);
  assign tik_nx  = ms_tick ? '0 : tik_q + 1'b1;

  // zero elapsed time means "too fast to measure"
  always_comb begin
    if (total_q == '0 || 64'(div_quo) > SPD_MAX) spd_sat = '1;
    else spd_sat = WIDTH_SPEED'(div_quo);
  end

  always_comb begin
    state_d   = state_q;
    tik_d     = tik_q;
    seg_ms_d  = seg_ms_q;
    total_d   = total_q;
    seg_d     = seg_q;
    epass_d   = epass_q;
    hold_d    = hold_q;
    speed_d   = speed_q;
    over_d    = over_q;
    fault_d   = fault_q;
    barrier_d = barrier_q;
    sv_d      = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && rise[0]) begin
          state_d  = TRANSIT;
          tik_d    = '0;
          seg_ms_d = '0;
          total_d  = '0;
          epass_d  = EPASS_NONE;
          seg_d    = SW'(1);
        end
      end
      TRANSIT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (seg_ms_q == MS_MAX) begin
          state_d   = IDLE;
          fault_d   = 1'b1;
          done_d    = 1'b1;
          barrier_d = 1'b0;
        end else begin
          tik_d = tik_nx;
          if (ms_tick) seg_ms_d = seg_ms_q + 1'b1;
          if (epass_q == EPASS_NONE) epass_d = valid_Epass;
          // a ms completing on the edge cycle still belongs to this segment
          if (rise[seg_q]) begin
            total_d  = total_q + TW'(seg_ms_q) + TW'(ms_tick);
            seg_ms_d = '0;
            tik_d    = '0;
            if (seg_q == SEG_LAST) state_d = DIVIDE;
            else seg_d = seg_q + 1'b1;
          end
        end
      end
      DIVIDE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (div_ready) begin
          state_d   = DECIDE;
          speed_d   = spd_sat;
          over_d    = 32'(spd_sat) > LIMIT;
          fault_d   = 1'b0;
          sv_d      = 1'b1;
          done_d    = 1'b1;
          barrier_d = (epass_q == EPASS_VALID);
        end
      end
      DECIDE: begin
        tik_d   = '0;
        hold_d  = '0;
        state_d = barrier_q ? HOLD : IDLE;
      end
      HOLD: begin
        tik_d = tik_nx;
        if (ms_tick) begin
          if (hold_q == HOLD_LAST) begin
            barrier_d = 1'b0;
            state_d   = IDLE;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tik_q     <= '0;
      seg_ms_q  <= '0;
      total_q   <= '0;
      seg_q     <= '0;
      epass_q   <= '0;
      hold_q    <= '0;
      speed_q   <= '0;
      over_q    <= 1'b0;
      fault_q   <= 1'b0;
      barrier_q <= 1'b0;
      sv_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tik_q     <= tik_d;
      seg_ms_q  <= seg_ms_d;
      total_q   <= total_d;
      seg_q     <= seg_d;
      epass_q   <= epass_d;
      hold_q    <= hold_d;
      speed_q   <= speed_d;
      over_q    <= over_d;
      fault_q   <= fault_d;
      barrier_q <= barrier_d;
      sv_q      <= sv_d;
      done_q    <= done_d;
    end
  end

  assign speed       = speed_q;
  assign speed_valid = sv_q;
  assign done        = done_q;
  assign barrier     = barrier_q;
  assign overspeed   = over_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_etc_lane_ctrl.sv
// Bench for etc_lane_ctrl at TIK_PER_MS=10: vector table of passes
// plus hand sequences for timeout, ordering, enable drop and reset.
module tb_etc_lane_ctrl;

  logic        clk;
  logic        reset_n;
  logic [2:0]  sensor;
  logic [1:0]  valid_Epass;
  logic        enable;
  logic [13:0] speed;
  logic        speed_valid;
  logic        done;
  logic        barrier;
  logic        overspeed;
  logic        fault;

  etc_lane_ctrl #(
    .NUM_SENSORS (3),
    .WIDTH_TIK   (16),
    .TIK_PER_MS  (10),
    .WIDTH_MS    (9),
    .WIDTH_SPEED (14),
    .GAP_CM      (500),
    .SPEED_LIMIT (3333),
    .HOLD_MS     (300)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sensor      (sensor),
    .valid_Epass (valid_Epass),
    .enable      (enable),
    .speed       (speed),
    .speed_valid (speed_valid),
    .done        (done),
    .barrier     (barrier),
    .overspeed   (overspeed),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sp;
    logic [1:0] e1;
    logic [1:0] e2;
    int         spd;
    logic       ov;
    logic       bar;
  } vec_t;

  typedef struct {
    logic [13:0] spd;
    logic        ov;
    logic        bar;
    logic        flt;
    logic        sv;
  } exp_t;

  exp_t sb[$];
  int n_pass;
  int n_total;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int idx);
    sensor[idx] = 1'b1;
    cyc(5);
    sensor[idx] = 1'b0;
  endtask

  task automatic push_exp(input int spd, input logic ov, input logic bar,
                          input logic flt, input logic sv);
    exp_t e;
    e.spd = 14'(spd);
    e.ov  = ov;
    e.bar = bar;
    e.flt = flt;
    e.sv  = sv;
    sb.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_speed"}, 64'(speed), 64'(e.spd));
      chk({tag, "_overspeed"}, 64'(overspeed), 64'(e.ov));
      chk({tag, "_barrier"}, 64'(barrier), 64'(e.bar));
      chk({tag, "_fault"}, 64'(fault), 64'(e.flt));
      chk({tag, "_speed_valid"}, 64'(speed_valid), 64'(e.sv));
    end
  endtask

  task automatic final_edge(output int n);
    sensor[2] = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
      if (n == 5) sensor[2] = 1'b0;
    end
    sensor[2] = 1'b0;
  endtask

  task automatic hold_check(input string tag);
    int m;
    int d;
    m = 0;
    d = 0;
    while (barrier === 1'b1 && m < 4000) begin
      if (m == 100) sensor[0] = 1'b1;
      if (m == 105) sensor[0] = 1'b0;
      if (done === 1'b1) d++;
      cyc(1);
      m++;
    end
    chk_rng({tag, "_hold_len"}, m, 2998, 3001);
    for (int i = 0; i < 50; i++) begin
      if (done === 1'b1) d++;
      cyc(1);
    end
    chk({tag, "_hold_no_done"}, 64'(d), 64'd0);
  endtask

  task automatic drive_pass(input string tag, input int sp,
                            input logic [1:0] e1, input logic [1:0] e2,
                            input int spd, input logic ov,
                            input logic bar, input bit meas);
    int n;
    push_exp(spd, ov, bar, 1'b0, 1'b1);
    valid_Epass = e1;
    pulse(0);
    cyc(sp * 10 - 5);
    pulse(1);
    valid_Epass = e2;
    cyc(sp * 10 - 5);
    final_edge(n);
    chk({tag, "_latency"}, 64'(n), 64'd24);
    check_out(tag);
    valid_Epass = 2'b00;
    cyc(1);
    chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
    chk({tag, "_sv_1cyc"}, 64'(speed_valid), 64'd0);
    if (meas && bar) hold_check(tag);
  endtask

  vec_t vecs[4];

  initial begin
    int n;
    int d;
    n_pass = 0;
    n_total = 0;
    vecs[0] = '{sp: 100, e1: 2'b10, e2: 2'b01, spd: 5000,  ov: 1'b1, bar: 1'b1};
    vecs[1] = '{sp: 250, e1: 2'b01, e2: 2'b10, spd: 2000,  ov: 1'b0, bar: 1'b0};
    vecs[2] = '{sp: 25,  e1: 2'b11, e2: 2'b10, spd: 16383, ov: 1'b1, bar: 1'b0};
    vecs[3] = '{sp: 250, e1: 2'b00, e2: 2'b10, spd: 2000,  ov: 1'b0, bar: 1'b1};

    reset_n = 1'b0;
    sensor = '0;
    valid_Epass = 2'b00;
    enable = 1'b1;
    cyc(3);
    chk("rst_speed", 64'(speed), 64'd0);
    chk("rst_sv", 64'(speed_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_barrier", 64'(barrier), 64'd0);
    chk("rst_overspeed", 64'(overspeed), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    reset_n = 1'b1;
    cyc(5);

    for (int i = 0; i < 4; i++) begin
      drive_pass($sformatf("vec%0d", i), vecs[i].sp, vecs[i].e1,
                 vecs[i].e2, vecs[i].spd, vecs[i].ov, vecs[i].bar, 1'b1);
      cyc(20);
    end

    // segment timeout: previous result stays on the outputs
    push_exp(2000, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse(0);
    n = 0;
    while (done !== 1'b1 && n < 6000) begin
      cyc(1);
      n++;
    end
    chk_rng("timeout_lat", n, 5100, 5120);
    check_out("timeout");
    cyc(1);
    chk("timeout_done_1cyc", 64'(done), 64'd0);
    chk("timeout_fault_latched", 64'(fault), 64'd1);
    cyc(20);

    // out-of-order sensor2 edge is ignored
    push_exp(5000, 1'b1, 1'b0, 1'b0, 1'b1);
    pulse(0);
    cyc(495);
    pulse(2);
    cyc(495);
    pulse(1);
    cyc(995);
    final_edge(n);
    chk("order_latency", 64'(n), 64'd24);
    check_out("order");
    cyc(20);

    // enable dropped mid-transit aborts without done
    pulse(0);
    cyc(495);
    d = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i == 0) enable = 1'b0;
      if (i == 3) enable = 1'b1;
      if (i == 495) sensor[1] = 1'b1;
      if (i == 500) sensor[1] = 1'b0;
      if (i == 995) sensor[2] = 1'b1;
      if (i == 1000) sensor[2] = 1'b0;
      if (done === 1'b1) d++;
      cyc(1);
    end
    chk("endrop_no_done", 64'(d), 64'd0);
    chk("endrop_speed", 64'(speed), 64'd5000);
    chk("endrop_barrier", 64'(barrier), 64'd0);

    // reset in the middle of a barrier hold
    drive_pass("prereset", 100, 2'b10, 2'b10, 5000, 1'b1, 1'b1, 1'b0);
    cyc(500);
    chk("prereset_barrier", 64'(barrier), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rst_async_barrier", 64'(barrier), 64'd0);
    chk("rst_async_speed", 64'(speed), 64'd0);
    chk("rst_async_overspeed", 64'(overspeed), 64'd0);
    @(posedge clk);
    #1;
    cyc(2);
    reset_n = 1'b1;
    d = 0;
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1 || barrier === 1'b1) d++;
      cyc(1);
    end
    chk("postreset_quiet", 64'(d), 64'd0);

    drive_pass("recover", 250, 2'b01, 2'b01, 2000, 1'b0, 1'b0, 1'b0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
